mux_8_32: RTL and testbench
===========================

# mux_8_32

Byte-to-word assembler for the PCIe physical-layer datapath. Receives a byte stream on the 4× clock, MSB byte first, and packs each group of four consecutive valid bytes into a 32-bit word. It is the receive-side counterpart of the 32→8 demultiplexer: a word split by that block and fed back here is reconstructed bit-exact. A 1-cycle error pulse flags streams that stop in the middle of a word.

## Interface
Parameters:
- None; widths fixed at 8 in / 32 out (constants from the shared defines file).

Ports:
- clk_4f  input  1  byte-rate clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk_4f
- data_in  input  8  incoming byte; first byte of a word is the MSB
- valid  input  1  data_in holds a valid byte this cycle
- data_out  output  32  last completed word, {b0,b1,b2,b3}
- valid_out  output  1  data_out holds a completed word
- err_out  output  1  1-cycle pulse: stream ended with 1–3 bytes of a partial word

## Operation
- State: 2-bit byte index `sel` (0..3), 24-bit partial-word register `acc`, output registers.
- Reset (reset==0 at an edge): sel=0, acc=0, data_out=32'h0, valid_out=0, err_out=0. Reset overrides valid.
- valid==1, sel=0: acc[23:16]<=data_in; sel<=1.
- valid==1, sel=1: acc[15:8]<=data_in; sel<=2.
- valid==1, sel=2: acc[7:0]<=data_in; sel<=3.
- valid==1, sel=3: data_out<={acc,data_in}; valid_out<=1; sel<=0 (wrap).
- In all valid==1 cases, data_out and valid_out are unchanged except at sel=3.
- valid==0: sel<=0; acc<=0; data_out<=0; valid_out<=0; err_out<=1 only if sel!=0 that cycle, else 0.
- err_out is 0 in every cycle not covered above; it is never high for two consecutive cycles.
- A partial word is discarded and never reaches data_out.
- A new word starts with the first valid byte after any valid==0 cycle or reset.

## Timing
- Latency: data_out/valid_out update at the same edge that samples the 4th byte and are visible in the following cycle.
- Continuous valid stream: valid_out rises after the 4th byte and then stays 1. data_out changes once every 4 cycles and is stable for the 3 cycles in between.
- valid drop: valid_out and data_out go to 0 one cycle after the first valid==0 sample. err_out is high in that same cycle, if applicable.
- valid drop on the cycle right after a word completes (sel=0): no error. The completed word stays visible for exactly 1 cycle.
- Reset released mid-stream: counting starts at the first edge with reset==1 and valid==1. Bytes sampled during reset are dropped.
- Round trip with the 32→8 demux on the same clk_4f: word w at the demux input appears here 5 cycles after the demux samples it (1 demux register stage + 4 bytes).

## Structure
- Shared defines file (PHY common): BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, SEL_W=2. Used by this block and the demux.
- No sub-module. Single always block on clk_4f, all outputs registered.
- RTL target: ~120–160 lines.

## Test plan
- Reset: hold reset=0 for 3 cycles with valid=1, data_in=8'hFF -> data_out=0, valid_out=0, err_out=0 throughout.
- Single word: bytes 8'hDE,8'hAD,8'hBE,8'hEF with valid=1 -> data_out=32'hDEADBEEF, valid_out=1 one cycle after the 4th byte. Then valid=0 -> outputs 0, err_out=0.
- Back-to-back: 8 consecutive bytes 01..08 -> data_out=32'h01020304 for 4 cycles, then 32'h05060708. valid_out stays 1 with no gap.
- Partial abort: bytes AA,BB then valid=0 -> err_out=1 for exactly 1 cycle, valid_out=0. A following word 11,22,33,44 -> 32'h11223344 (no residue of AA/BB).
- Reset mid-word: bytes 01,02, then reset=0 for 1 cycle, then 10,20,30,40 -> 32'h10203040, err_out=0.
- Loopback: demux_32_8 → mux_8_32 with random words and random valid gaps. Every complete word matches the input exactly. err_out is asserted exactly when valid fell mid-word.

Source files
------------

// File: rtl/mux_8_32_pkg.sv
// Shared PHY datapath constants for the byte/word mux and demux pair.
// Also provides the word-packing helper used by the assembler.
package mux_8_32_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int SEL_W          = 2;
    localparam int ACC_W          = WORD_W - BYTE_W;

    localparam logic [SEL_W-1:0] SEL_B0 = 2'd0;
    localparam logic [SEL_W-1:0] SEL_B1 = 2'd1;
    localparam logic [SEL_W-1:0] SEL_B2 = 2'd2;
    localparam logic [SEL_W-1:0] SEL_B3 = 2'd3;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [ACC_W-1:0]  acc,
        input logic [BYTE_W-1:0] last
    );
        return {acc, last};
    endfunction

endpackage

// File: rtl/mux_8_32.sv
// Byte-to-word assembler: packs four valid bytes (MSB first) into a word.
// A stream that stops mid-word drops the partial word and pulses err_out.
module mux_8_32
    import mux_8_32_pkg::*;
(
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              err_out
);

    logic [SEL_W-1:0] sel;
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            sel       <= SEL_B0;
            acc       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            err_out   <= 1'b0;
        end else if (valid) begin
            err_out <= 1'b0;
            sel     <= sel + 2'd1;
            unique case (sel)
                SEL_B0: acc[23:16] <= data_in;
                SEL_B1: acc[15:8]  <= data_in;
                SEL_B2: acc[7:0]   <= data_in;
                SEL_B3: begin
                    data_out  <= pack_word(acc, data_in);
                    valid_out <= 1'b1;
                end
            endcase
        end else begin
            // Gap: flush everything; flag only if a word was in progress
            sel       <= SEL_B0;
            acc       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            err_out   <= (sel != SEL_B0);
        end
    end

endmodule

// File: tb/tb_mux_8_32.sv
// Directed and randomized-word bench for the byte-to-word assembler.
// Inputs are driven before each rising edge, outputs sampled 1ns after.
module tb_mux_8_32;

    logic        clk_4f;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid;
    logic [31:0] data_out;
    logic        valid_out;
    logic        err_out;

    int passed;
    int total;

    mux_8_32 dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in   (data_in),
        .valid     (valid),
        .data_out  (data_out),
        .valid_out (valid_out),
        .err_out   (err_out)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        @(negedge clk_4f);
        reset   = r;
        valid   = v;
        data_in = b;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] ed,
                       input logic ev, input logic ee);
        total++;
        assert (data_out === ed) passed++;
        else $error("FAIL %s data_out got %h want %h", tag, data_out, ed);
        total++;
        assert (valid_out === ev) passed++;
        else $error("FAIL %s valid_out got %b want %b", tag, valid_out, ev);
        total++;
        assert (err_out === ee) passed++;
        else $error("FAIL %s err_out got %b want %b", tag, err_out, ee);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] last;
        int          k;
        passed  = 0;
        total   = 0;
        reset   = 1'b0;
        valid   = 1'b0;
        data_in = 8'h00;

        // Reset dominates valid
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'hFF);
            chk("reset", 32'h0, 1'b0, 1'b0);
        end

        // Single word then clean drop
        step(1'b1, 1'b1, 8'hDE); chk("sw_b0", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hAD); chk("sw_b1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hBE); chk("sw_b2", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hEF); chk("sw_b3", 32'hDEADBEEF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00); chk("sw_drop", 32'h0, 1'b0, 1'b0);

        // Back-to-back words
        step(1'b1, 1'b1, 8'h01); chk("bb_1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h02); chk("bb_2", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h03); chk("bb_3", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h04); chk("bb_4", 32'h01020304, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h05); chk("bb_5", 32'h01020304, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h06); chk("bb_6", 32'h01020304, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h07); chk("bb_7", 32'h01020304, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h08); chk("bb_8", 32'h05060708, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00); chk("bb_drop", 32'h0, 1'b0, 1'b0);

        // Partial abort, then a clean word with no residue
        step(1'b1, 1'b1, 8'hAA); chk("pa_1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hBB); chk("pa_2", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00); chk("pa_err", 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 8'h00); chk("pa_err_end", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h11); chk("pa_n1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22); chk("pa_n2", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h33); chk("pa_n3", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h44); chk("pa_n4", 32'h11223344, 1'b1, 1'b0);

        // Abort after 3 bytes while previous word visible
        step(1'b1, 1'b1, 8'h55); chk("a3_1", 32'h11223344, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h66); chk("a3_2", 32'h11223344, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'h77); chk("a3_3", 32'h11223344, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h88); chk("a3_err", 32'h0, 1'b0, 1'b1);

        // Reset mid-word
        step(1'b1, 1'b1, 8'h01); chk("rm_1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h02); chk("rm_2", 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h03); chk("rm_rst", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h10); chk("rm_n1", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h20); chk("rm_n2", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h30); chk("rm_n3", 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h40); chk("rm_n4", 32'h10203040, 1'b1, 1'b0);
        last = 32'h10203040;

        // Random words, gaps and aborts as a demux would deliver them
        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            k = int'($urandom_range(0, 5));
            if (k == 0) begin
                step(1'b1, 1'b0, 8'h00);
                chk("rnd_gap", 32'h0, 1'b0, 1'b0);
                last = 32'h0;
            end else if (k <= 3) begin
                for (int i = 0; i < k; i++) begin
                    step(1'b1, 1'b1, w[31-8*i -: 8]);
                    chk("rnd_part", last, last != 32'h0 || n < 0, 1'b0);
                end
                step(1'b1, 1'b0, 8'h00);
                chk("rnd_abort", 32'h0, 1'b0, 1'b1);
                last = 32'h0;
            end else begin
                for (int i = 0; i < 3; i++)
                    step(1'b1, 1'b1, w[31-8*i -: 8]);
                step(1'b1, 1'b1, w[7:0]);
                chk("rnd_word", w, 1'b1, 1'b0);
                last = w;
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
